uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core.sv | 141 ++++++++++++++
 tb/tb_uart_tx_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// Parameterised UART transmitter: start bit, LSB-first payload, optional parity, 1 or 2 stop bits.
// A one-cycle done pulse marks frame completion; the next frame can be accepted in that same cycle.
module uart_tx_core #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              Tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic              stop_idx, stop_idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              tx_r, tx_n;
    logic              done_r, done_n;
    logic              bit_end;
    logic              parity_bit;

    assign bit_end    = (cnt == CNT_LAST);
    assign parity_bit = (PARITY_MODE == 2) ? ~(^shreg) : ^shreg;

    assign ready = (state == IDLE) && !rst;
    assign busy  = (state != IDLE);
    assign Tx    = tx_r;
    assign done  = done_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            tx_r     <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            stop_idx <= stop_idx_n;
            shreg    <= shreg_n;
            tx_r     <= tx_n;
            done_r   <= done_n;
        end
    end

    // Tx is registered: each branch loads the level of the bit that starts at the coming edge.
    always_comb begin
        state_n    = state;
        cnt_n      = bit_end ? '0 : cnt + CNT_W'(1);
        idx_n      = idx;
        stop_idx_n = stop_idx;
        shreg_n    = shreg;
        tx_n       = tx_r;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (valid && ready) begin
                    state_n    = START;
                    shreg_n    = data;
                    tx_n       = 1'b0;
                    idx_n      = '0;
                    stop_idx_n = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == IDX_LAST) begin
                        stop_idx_n = 1'b0;
                        if (PARITY_MODE != 0) begin
                            state_n = PARITY;
                            tx_n    = parity_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        idx_n = idx + IDX_W'(1);
                        tx_n  = shreg[idx + IDX_W'(1)];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n    = STOP;
                    stop_idx_n = 1'b0;
                    tx_n       = 1'b1;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: four configurations share clk/rst/data, each with its own
// valid and outputs; expected Tx levels are queued per cycle at handshake and compared as the frame plays out.
module tb_uart_tx_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_bus = '0;
    logic [3:0] valid_v = '0;
    logic [3:0] ready_v, tx_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    // DUT configurations: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 7N2
    int cfg_dw[4]  = '{8, 8, 8, 7};
    int cfg_cpb[4] = '{4, 4, 4, 3};
    int cfg_pm[4]  = '{0, 1, 2, 0};
    int cfg_sb[4]  = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    uart_tx_core #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .data(data_bus), .valid(valid_v[0]), .ready(ready_v[0]),
        .Tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    uart_tx_core #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .data(data_bus), .valid(valid_v[1]), .ready(ready_v[1]),
        .Tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    uart_tx_core #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .data(data_bus), .valid(valid_v[2]), .ready(ready_v[2]),
        .Tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    uart_tx_core #(.DATA_W(7), .CLKS_PER_BIT(3), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .data(data_bus[6:0]), .valid(valid_v[3]), .ready(ready_v[3]),
        .Tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    // Reference frame: start, payload LSB first, optional parity, stop bits; one entry per clock.
    task automatic expect_frame(input int s, input logic [7:0] v);
        bit bits[$];
        bit par;
        par = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < cfg_dw[s]; i++) begin
            bits.push_back(v[i]);
            par ^= v[i];
        end
        if (cfg_pm[s] == 1) bits.push_back(par);
        else if (cfg_pm[s] == 2) bits.push_back(!par);
        for (int i = 0; i < cfg_sb[s]; i++) bits.push_back(1'b1);
        foreach (bits[b]) repeat (cfg_cpb[s]) exp_q.push_back(bits[b]);
    endtask

    task automatic wait_ready(input int s);
        int n;
        n = 0;
        while (ready_v[s] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready_v[s] !== 1'b1) begin
            $display("FAIL ready_timeout dut%0d: ready=%b, required 1", s, ready_v[s]);
            errors++;
        end
    endtask

    // Called at a negedge with valid already set; the handshake happens at the next posedge.
    task automatic watch_frame(input int s, input bit keep_valid, input logic [7:0] new_data,
                               input int disturb_at);
        int i;
        bit e;
        i = 0;
        @(posedge clk);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (tx_v[s] !== e) begin
                $display("FAIL tx dut%0d cycle %0d: Tx=%b, required %b", s, i, tx_v[s], e);
                errors++;
            end
            checks++;
            if (busy_v[s] !== 1'b1 || done_v[s] !== 1'b0) begin
                $display("FAIL in_frame dut%0d cycle %0d: busy=%b done=%b, required busy=1 done=0",
                         s, i, busy_v[s], done_v[s]);
                errors++;
            end
            if (i == 0) begin
                data_bus = new_data;
                if (!keep_valid) valid_v[s] = 1'b0;
            end
            if (disturb_at > 0 && i == disturb_at) begin
                valid_v[s] = 1'b1;
                data_bus   = ~data_bus;
            end
            if (disturb_at > 0 && i == disturb_at + 1) valid_v[s] = 1'b0;
            i++;
        end
        @(negedge clk);
        checks++;
        if ({done_v[s], busy_v[s], tx_v[s], ready_v[s]} !== 4'b1011) begin
            $display("FAIL frame_end dut%0d: done=%b busy=%b Tx=%b ready=%b, required 1 0 1 1",
                     s, done_v[s], busy_v[s], tx_v[s], ready_v[s]);
            errors++;
        end
        if (!keep_valid) begin
            @(negedge clk);
            checks++;
            if ({done_v[s], busy_v[s], tx_v[s]} !== 3'b001) begin
                $display("FAIL done_pulse dut%0d: done=%b busy=%b Tx=%b, required 0 0 1",
                         s, done_v[s], busy_v[s], tx_v[s]);
                errors++;
            end
        end
    endtask

    task automatic send(input int s, input logic [7:0] v, input int disturb_at);
        wait_ready(s);
        data_bus   = v;
        valid_v[s] = 1'b1;
        expect_frame(s, v);
        watch_frame(s, 1'b0, ~v, disturb_at);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        valid_v  = '1;
        data_bus = 8'hFF;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if ({ready_v[s], tx_v[s], busy_v[s], done_v[s]} !== 4'b0100) begin
                $display("FAIL reset_state dut%0d: ready=%b Tx=%b busy=%b done=%b, required 0 1 0 0",
                         s, ready_v[s], tx_v[s], busy_v[s], done_v[s]);
                errors++;
            end
        end
        rst     = 1'b0;
        valid_v = '0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if ({ready_v[s], tx_v[s], busy_v[s]} !== 3'b110) begin
                $display("FAIL reset_release dut%0d: ready=%b Tx=%b busy=%b, required 1 1 0",
                         s, ready_v[s], tx_v[s], busy_v[s]);
                errors++;
            end
        end
    endtask

    task automatic test_8n1();
        send(0, 8'hA5, 0);
        send(0, 8'h00, 0);
    endtask

    task automatic test_parity();
        send(1, 8'h07, 0);
        send(2, 8'h07, 0);
        send(1, 8'hB4, 0);
        send(2, 8'hB4, 0);
    endtask

    task automatic test_7n2();
        send(3, 8'h55, 0);
        send(3, 8'h2A, 0);
    endtask

    task automatic test_back_to_back();
        wait_ready(0);
        data_bus   = 8'h3C;
        valid_v[0] = 1'b1;
        expect_frame(0, 8'h3C);
        watch_frame(0, 1'b1, 8'hC3, 0);
        expect_frame(0, 8'hC3);
        watch_frame(0, 1'b0, 8'hFF, 10);
    endtask

    task automatic test_reset_mid();
        bit e;
        wait_ready(0);
        data_bus   = 8'hA5;
        valid_v[0] = 1'b1;
        expect_frame(0, 8'hA5);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (tx_v[0] !== e) begin
                $display("FAIL pre_abort_tx cycle %0d: Tx=%b, required %b", i, tx_v[0], e);
                errors++;
            end
            if (i == 0) valid_v[0] = 1'b0;
        end
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_v[0], busy_v[0], done_v[0], ready_v[0]} !== 4'b1000) begin
            $display("FAIL abort_state: Tx=%b busy=%b done=%b ready=%b, required 1 0 0 0",
                     tx_v[0], busy_v[0], done_v[0], ready_v[0]);
            errors++;
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({tx_v[0], busy_v[0], done_v[0], ready_v[0]} !== 4'b1001) begin
                $display("FAIL post_abort cycle %0d: Tx=%b busy=%b done=%b ready=%b, required 1 0 0 1",
                         i, tx_v[0], busy_v[0], done_v[0], ready_v[0]);
                errors++;
            end
        end
        send(0, 8'h5A, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
